// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// The optional marker/verify feature is controlled by the CCFF_VERIFY_EN macro.
package ccff_loader_pkg;

    localparam int CCFF_BYTE_W = 8;
    localparam logic [CCFF_BYTE_W-1:0] CCFF_MARKER = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARKER,
        ST_LOAD,
        ST_DONE
    } state_t;

    // Number of bitstream bytes needed to cover a chain of the given length.
    function automatic int ccff_num_bytes(input int chain_len);
        return (chain_len + CCFF_BYTE_W - 1) / CCFF_BYTE_W;
    endfunction

endpackage

// File: rtl/ccff_byte_serializer.sv
// Byte-to-bit serializer for the configuration chain loader.
// A holding byte sits in front of an 8-bit shift register. The final byte of a
// load is loaded with only the bits the chain still needs, so surplus low-order
// bits are dropped rather than shifted.
module ccff_byte_serializer
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 48
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic                   clear,
    input  logic                   accept_en,
    input  logic [CCFF_BYTE_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   shift,
    output logic                   bit_avail,
    output logic                   head_bit
);

    localparam int NUM_BYTES = ccff_num_bytes(CHAIN_LEN);
    localparam int BCNT_W    = $clog2(NUM_BYTES + 1);
    localparam int LAST_BITS = CHAIN_LEN - CCFF_BYTE_W * (NUM_BYTES - 1);
    localparam logic [3:0] FULL_CNT = 4'(CCFF_BYTE_W);
    localparam logic [3:0] LAST_CNT = 4'(LAST_BITS);

    logic [CCFF_BYTE_W-1:0] hold_data;
    logic                   hold_full;
    logic                   hold_last;
    logic [CCFF_BYTE_W-1:0] shreg;
    logic [3:0]             bit_cnt;
    logic [BCNT_W-1:0]      accepted;
    logic                   handshake;
    logic                   in_is_last;
    logic                   sr_empty_next;
    logic                   reload_hold;
    logic                   reload_in;

    assign in_ready      = accept_en && !hold_full && (accepted < BCNT_W'(NUM_BYTES));
    assign handshake     = in_valid && in_ready;
    assign in_is_last    = (accepted == BCNT_W'(NUM_BYTES - 1));
    assign sr_empty_next = (bit_cnt == 4'd0) || (shift && (bit_cnt == 4'd1));
    assign reload_hold   = sr_empty_next && hold_full;
    assign reload_in     = sr_empty_next && !hold_full && handshake;
    assign bit_avail     = (bit_cnt != 4'd0);
    assign head_bit      = shreg[CCFF_BYTE_W-1];

    // Holding byte, shift register and byte counter; an incoming byte bypasses the holding byte when the shift register is draining.
    always_ff @(posedge prog_clk) begin
        if (!pReset || clear) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            hold_last <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= 4'd0;
            accepted  <= '0;
        end else begin
            if (handshake) begin
                accepted <= accepted + BCNT_W'(1);
            end
            if (reload_hold) begin
                shreg     <= hold_data;
                bit_cnt   <= hold_last ? LAST_CNT : FULL_CNT;
                hold_full <= 1'b0;
            end else if (reload_in) begin
                shreg   <= in_data;
                bit_cnt <= in_is_last ? LAST_CNT : FULL_CNT;
            end else begin
                if (shift && bit_avail) begin
                    shreg   <= {shreg[CCFF_BYTE_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt - 4'd1;
                end
                if (handshake) begin
                    hold_data <= in_data;
                    hold_full <= 1'b1;
                    hold_last <= in_is_last;
                end
            end
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: serialises the bitstream MSB-first onto the
// chain and gates the chain shift. Defining CCFF_VERIFY_EN prefixes the
// stream with a marker byte and checks it as it emerges from ccff_tail.
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 48,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 9)
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic                   start,
    input  logic [CCFF_BYTE_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   ccff_head,
    output logic                   ccff_shift_en,
    input  logic                   ccff_tail,
    output logic                   busy,
    output logic                   done,
    output logic                   verify_ok,
    output logic [CNT_W-1:0]       shift_count
);

`ifdef CCFF_VERIFY_EN
    localparam int TOTAL_SHIFTS = CHAIN_LEN + CCFF_BYTE_W;
`else
    localparam int TOTAL_SHIFTS = CHAIN_LEN;
`endif

    state_t state;
    state_t next_state;
    logic   ser_clear;
    logic   accept_en;
    logic   ser_shift;
    logic   bit_avail;
    logic   head_bit;

    ccff_byte_serializer #(
        .CHAIN_LEN(CHAIN_LEN)
    ) u_serializer (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clear    (ser_clear),
        .accept_en(accept_en),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .shift    (ser_shift),
        .bit_avail(bit_avail),
        .head_bit (head_bit)
    );

`ifdef CCFF_VERIFY_EN
    logic [2:0] marker_idx;
    assign marker_idx = 3'd7 - shift_count[2:0];
`endif

    // Next-state logic plus the chain drive; a LOAD cycle with no bit ready simply stalls the chain.
    always_comb begin
        next_state    = state;
        ser_clear     = 1'b0;
        accept_en     = 1'b0;
        ser_shift     = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        busy          = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ser_clear = 1'b1;
`ifdef CCFF_VERIFY_EN
                    next_state = ST_MARKER;
`else
                    next_state = ST_LOAD;
`endif
                end
            end
`ifdef CCFF_VERIFY_EN
            ST_MARKER: begin
                busy          = 1'b1;
                accept_en     = 1'b1;
                ccff_shift_en = 1'b1;
                ccff_head     = CCFF_MARKER[marker_idx];
                if (shift_count == CNT_W'(CCFF_BYTE_W - 1)) begin
                    next_state = ST_LOAD;
                end
            end
`endif
            ST_LOAD: begin
                busy      = 1'b1;
                accept_en = 1'b1;
                if (bit_avail) begin
                    ccff_shift_en = 1'b1;
                    ccff_head     = head_bit;
                    ser_shift     = 1'b1;
                    if (shift_count == CNT_W'(TOTAL_SHIFTS - 1)) begin
                        next_state = ST_DONE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register and shift counter; a new start zeroes the count.
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state       <= ST_IDLE;
            shift_count <= '0;
        end else begin
            state <= next_state;
            if (ser_clear) begin
                shift_count <= '0;
            end else if (ccff_shift_en) begin
                shift_count <= shift_count + CNT_W'(1);
            end
        end
    end

    assign done = (state == ST_DONE);

`ifdef CCFF_VERIFY_EN
    logic       verify_err;
    logic [2:0] tail_idx;
    logic       tail_check;

    assign tail_idx   = 3'd7 - (shift_count[2:0] - 3'(CHAIN_LEN));
    assign tail_check = (state == ST_LOAD) && ccff_shift_en
                        && (shift_count >= CNT_W'(CHAIN_LEN));

    // Sticky marker-compare error: once the marker reaches the chain tail each emerging bit must match.
    always_ff @(posedge prog_clk) begin
        if (!pReset || ser_clear) begin
            verify_err <= 1'b0;
        end else if (tail_check && (ccff_tail != CCFF_MARKER[tail_idx])) begin
            verify_err <= 1'b1;
        end
    end

    assign verify_ok = done && !verify_err;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign verify_ok   = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Directed testbench for ccff_loader with behavioural models of a 48-FF and a
// 44-FF configuration chain. Expected values follow CCFF_VERIFY_EN.
module tb_ccff_loader;

`ifdef CCFF_VERIFY_EN
    localparam int TOT48     = 56;
    localparam int TOT44     = 52;
    localparam int NOM_CYC   = 56;
    localparam int NOM_STALL = 0;
    localparam int GAP       = 26;
    localparam int UND_CYC   = 61;
    localparam int UND_STALL = 5;
    localparam int VOK_GOOD  = 1;
    localparam int CNT_AT_31 = 31;
    localparam int P_CYC     = 52;
`else
    localparam int TOT48     = 48;
    localparam int TOT44     = 44;
    localparam int NOM_CYC   = 49;
    localparam int NOM_STALL = 1;
    localparam int GAP       = 19;
    localparam int UND_CYC   = 54;
    localparam int UND_STALL = 6;
    localparam int VOK_GOOD  = 0;
    localparam int CNT_AT_31 = 30;
    localparam int P_CYC     = 45;
`endif
    localparam int NB = 6;

    logic       prog_clk;
    logic       pReset;
    logic       start, in_valid, in_ready, ccff_head, ccff_shift_en, ccff_tail;
    logic       busy, done, verify_ok;
    logic [7:0] in_data;
    logic [5:0] shift_count;

    logic       start_b, in_valid_b, ready_b, head_b, sen_b, tail_b;
    logic       busy_b, done_b, vok_b;
    logic [7:0] in_data_b;
    logic [5:0] cnt_b;

    logic [47:0] chain_a;
    logic [43:0] chain_b;
    int          shifts_a = 0;
    int          shifts_b = 0;
    bit          broken;

    int errors = 0;
    int checks = 0;
    int cycles, stalls, load_shifts;
    bit aborted;
    logic [7:0] stream_bytes [NB];

    ccff_loader #(.CHAIN_LEN(48)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .verify_ok(verify_ok), .shift_count(shift_count)
    );

    ccff_loader #(.CHAIN_LEN(44)) dut44 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(ready_b),
        .ccff_head(head_b), .ccff_shift_en(sen_b), .ccff_tail(tail_b),
        .busy(busy_b), .done(done_b), .verify_ok(vok_b), .shift_count(cnt_b)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Fabric models: each gated edge shifts the chain by one position.
    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain_a  <= {chain_a[46:0], ccff_head};
            shifts_a <= shifts_a + 1;
        end
        if (sen_b) begin
            chain_b  <= {chain_b[42:0], head_b};
            shifts_b <= shifts_b + 1;
        end
    end

    assign ccff_tail = broken ? 1'b0 : chain_a[47];
    assign tail_b    = chain_b[43];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One load on the 48-FF instance, with optional byte gap, busy start pulse and mid-load reset.
    task automatic applyStimulus(input bit brk, input int gap, input int pulse_at,
                                 input int cnt_at_pulse, input int reset_at);
        int idx, cyc, gap_left, base;
        bit ready_checked;
        broken = brk; idx = 0; cyc = 0; gap_left = 0; ready_checked = 0;
        stalls = 0; aborted = 0;
        @(negedge prog_clk); start = 1'b1;
        @(negedge prog_clk); start = 1'b0;
        base = shifts_a;
        while (!done && cyc < 400) begin
            if (reset_at >= 0 && (shifts_a - base) == reset_at) begin
                pReset = 1'b0; in_valid = 1'b0;
                @(negedge prog_clk);
                checkOutput("rst_in_ready", in_ready, 0);
                checkOutput("rst_head", ccff_head, 0);
                checkOutput("rst_shift_en", ccff_shift_en, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_done", done, 0);
                checkOutput("rst_verify_ok", verify_ok, 0);
                checkOutput("rst_shift_count", shift_count, 0);
                pReset = 1'b1; aborted = 1'b1;
                break;
            end
            if (busy && !ccff_shift_en) stalls++;
            start = (cyc == pulse_at);
            if (pulse_at >= 0 && cyc == pulse_at + 1) begin
                checkOutput("busy_start_count", shift_count, cnt_at_pulse);
                checkOutput("busy_start_busy", busy, 1);
            end
            if (idx == NB && !ready_checked) begin
                checkOutput("ready_after_last", in_ready, 0);
                ready_checked = 1'b1;
            end
            if (idx < NB && gap_left == 0) begin
                in_valid = 1'b1;
                in_data  = stream_bytes[idx];
                if (in_ready) begin
                    idx++;
                    if (idx == 2) gap_left = gap;
                end
            end else begin
                in_valid = 1'b0;
                if (gap_left > 0) gap_left--;
            end
            @(negedge prog_clk);
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0;
        cycles = cyc;
        load_shifts = shifts_a - base;
    endtask

    // Load on the 44-FF instance; keeps offering an extra byte after the sixth to show it is refused.
    task automatic applyPartial();
        int hs, cyc, base;
        bit ready_checked;
        hs = 0; cyc = 0; ready_checked = 0;
        @(negedge prog_clk); start_b = 1'b1;
        @(negedge prog_clk); start_b = 1'b0;
        base = shifts_b;
        while (!done_b && cyc < 400) begin
            if (hs == NB && !ready_checked) begin
                checkOutput("p_ready_after_last", ready_b, 0);
                ready_checked = 1'b1;
            end
            in_valid_b = 1'b1;
            in_data_b  = (hs < NB) ? stream_bytes[hs] : 8'hFF;
            if (ready_b) hs++;
            @(negedge prog_clk);
            cyc++;
        end
        in_valid_b = 1'b0;
        checkOutput("p_handshakes", hs, NB);
        checkOutput("p_done", done_b, 1);
        checkOutput("p_shift_count", cnt_b, TOT44);
        checkOutput("p_model_shifts", shifts_b - base, TOT44);
        checkOutput("p_cycles", cyc, P_CYC);
        checkOutput("p_chain", chain_b, 44'h123456789AB);
        checkOutput("p_verify_ok", vok_b, VOK_GOOD);
    endtask

    initial begin
        stream_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        pReset = 1'b0; broken = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        start_b = 1'b0; in_valid_b = 1'b0; in_data_b = 8'h00;
        repeat (3) @(negedge prog_clk);
        $display("[TB] reset state");
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_head", ccff_head, 0);
        checkOutput("reset_shift_en", ccff_shift_en, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_verify_ok", verify_ok, 0);
        checkOutput("reset_shift_count", shift_count, 0);
        checkOutput("reset_busy_b", busy_b, 0);
        pReset = 1'b1;

        $display("[TB] nominal load");
        applyStimulus(1'b0, 0, -1, 0, -1);
        checkOutput("nom_done", done, 1);
        checkOutput("nom_shift_count", shift_count, TOT48);
        checkOutput("nom_model_shifts", load_shifts, TOT48);
        checkOutput("nom_chain", chain_a, 48'h123456789ABC);
        checkOutput("nom_verify_ok", verify_ok, VOK_GOOD);
        checkOutput("nom_cycles", cycles, NOM_CYC);
        checkOutput("nom_stalls", stalls, NOM_STALL);
        checkOutput("nom_busy", busy, 0);
        repeat (3) @(negedge prog_clk);
        checkOutput("nom_done_sticky", done, 1);
        checkOutput("nom_idle_shift_en", ccff_shift_en, 0);

        $display("[TB] broken chain");
        applyStimulus(1'b1, 0, -1, 0, -1);
        checkOutput("brk_done", done, 1);
        checkOutput("brk_verify_ok", verify_ok, 0);
        checkOutput("brk_chain", chain_a, 48'h123456789ABC);

        $display("[TB] underrun");
        applyStimulus(1'b0, GAP, -1, 0, -1);
        checkOutput("und_done", done, 1);
        checkOutput("und_shift_count", shift_count, TOT48);
        checkOutput("und_stalls", stalls, UND_STALL);
        checkOutput("und_cycles", cycles, UND_CYC);
        checkOutput("und_chain", chain_a, 48'h123456789ABC);
        checkOutput("und_verify_ok", verify_ok, VOK_GOOD);

        $display("[TB] start while busy");
        applyStimulus(1'b0, 0, 30, CNT_AT_31, -1);
        checkOutput("sb_done", done, 1);
        checkOutput("sb_shift_count", shift_count, TOT48);
        checkOutput("sb_cycles", cycles, NOM_CYC);
        checkOutput("sb_chain", chain_a, 48'h123456789ABC);

        $display("[TB] reset mid-load");
        chain_a = 48'h0;
        applyStimulus(1'b0, 0, -1, 0, 20);
        checkOutput("mid_aborted", aborted, 1);
        applyStimulus(1'b0, 0, -1, 0, -1);
        checkOutput("mid_reload_done", done, 1);
        checkOutput("mid_reload_count", shift_count, TOT48);
        checkOutput("mid_reload_chain", chain_a, 48'h123456789ABC);
        checkOutput("mid_reload_verify_ok", verify_ok, VOK_GOOD);

        $display("[TB] partial final byte");
        applyPartial();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
